// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port (CPU/DMA) round-robin arbiter with burst limit for a single-port data memory
// Optional: DMEM_ARB_FIXED_PRIO_EN gives the CPU fixed priority when both ports request.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_owner
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic              last_dma_q, last_dma_d;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              cpu_rvalid_q, dma_rvalid_q;

  // Grant decision: a lone requester always wins; contention is resolved by owner/streak.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (cpu_req && dma_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      cpu_gnt = 1'b1;
`else
      case (owner_q)
        OWN_CPU: begin
          if (streak_q < 4'(MAX_BURST)) cpu_gnt = 1'b1;
          else                          dma_gnt = 1'b1;
        end
        OWN_DMA: begin
          if (streak_q < 4'(MAX_BURST)) dma_gnt = 1'b1;
          else                          cpu_gnt = 1'b1;
        end
        default: begin
          if (last_dma_q) cpu_gnt = 1'b1;
          else            dma_gnt = 1'b1;
        end
      endcase
`endif
    end else begin
      cpu_gnt = cpu_req;
      dma_gnt = dma_req;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_we;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_wen   = dma_we;
    end
  end

  always_comb begin
    owner_d    = owner_q;
    streak_d   = streak_q;
    last_dma_d = last_dma_q;
    if (cpu_gnt) begin
      last_dma_d = 1'b0;
      if (owner_q == OWN_CPU) begin
        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
      end else begin
        owner_d  = OWN_CPU;
        streak_d = 4'd1;
      end
    end else if (dma_gnt) begin
      last_dma_d = 1'b1;
      if (owner_q == OWN_DMA) begin
        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
      end else begin
        owner_d  = OWN_DMA;
        streak_d = 4'd1;
      end
    end else begin
      owner_d  = OWN_NONE;
      streak_d = 4'd0;
    end
  end

  // Reset takes priority over a same-cycle read, so no rvalid survives a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      streak_q     <= 4'd0;
      last_dma_q   <= 1'b1;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      streak_q     <= streak_d;
      last_dma_q   <= last_dma_d;
      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      dma_rvalid_q <= dma_gnt && !dma_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (dma_gnt && !dma_we) dma_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign arb_owner  = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic [1:0]  arb_owner;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_rdata(mem_rdata),
    .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as 0xC0DE0000 | addr.
  logic          mem_clr = 1'b1;
  logic [255:0]  wr_q;
  logic [31:0]   mem_q [0:255];
  always @(posedge clk) begin
    if (mem_clr) wr_q <= '0;
    else if (mem_wen) begin
      wr_q[mem_addr[7:0]]  <= 1'b1;
      mem_q[mem_addr[7:0]] <= mem_wdata;
    end
  end
  always_comb begin
    mem_rdata = 32'hC0DE0000 | {24'd0, mem_addr[7:0]};
    if (wr_q[mem_addr[7:0]]) mem_rdata = mem_q[mem_addr[7:0]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_clr = 1'b1;
    tick();
    tick();
    checks++; if (arb_owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %0h expected 0", arb_owner); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid got %0b expected 0", cpu_rvalid); end
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid got %0b expected 0", dma_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %0h expected 0", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata got %0h expected 0", dma_rdata); end
    checks++; if ({cpu_gnt, dma_gnt, mem_wen} !== 3'b000) begin errors++; $display("FAIL reset_gnt_wen got %0b expected 000", {cpu_gnt, dma_gnt, mem_wen}); end
    checks++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus got %0h/%0h expected 0/0", mem_addr, mem_wdata); end
    mem_clr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got %0b%0b expected 10", cpu_gnt, dma_gnt); end
    checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL wr_wen got %0b expected 1", mem_wen); end
    checks++; if (mem_addr !== 16'h0010 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus got %0h/%0h expected 10/deadbeef", mem_addr, mem_wdata); end
    tick();
    cpu_we = 1'b0;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || mem_wen !== 1'b0) begin errors++; $display("FAIL rd_gnt_wen got %0b/%0b expected 1/0", cpu_gnt, mem_wen); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %0b expected 0", cpu_rvalid); end
    tick();
    cpu_req = 1'b0;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %0b/%0h expected 1/deadbeef", cpu_rvalid, cpu_rdata); end
    checks++; if (arb_owner !== 2'b01) begin errors++; $display("FAIL rd_owner got %0h expected 1", arb_owner); end
    tick();
    checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %0b/%0h expected 0/deadbeef", cpu_rvalid, cpu_rdata); end
    checks++; if (arb_owner !== 2'b00) begin errors++; $display("FAIL idle_owner got %0h expected 0", arb_owner); end
  endtask

  task automatic test_dma_only;
    for (int i = 0; i < 10; i++) begin
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'(i); dma_wdata = 32'h10000000 + 32'(i) * 32'h11;
      #1;
      checks++; if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || mem_wen !== 1'b1) begin errors++; $display("FAIL dma_wr%0d got %0b%0b%0b expected 011", i, cpu_gnt, dma_gnt, mem_wen); end
      tick();
      checks++; if (arb_owner !== 2'b10) begin errors++; $display("FAIL dma_owner%0d got %0h expected 2", i, arb_owner); end
    end
    dma_req = 1'b0; dma_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL dma_rb_gnt got %0b expected 1", cpu_gnt); end
    tick();
    cpu_req = 1'b0;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h10000055) begin errors++; $display("FAIL dma_rb_data got %0b/%0h expected 1/10000055", cpu_rvalid, cpu_rdata); end
    checks++; if (arb_owner !== 2'b01) begin errors++; $display("FAIL dma_rb_owner got %0h expected 1", arb_owner); end
    tick();
  endtask

  task automatic test_round_robin;
    logic exp_cpu, prev_cpu, prev_dma;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_cpu = 1'b0; prev_dma = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0080;
    for (int i = 0; i < 20; i++) begin
      #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_cpu = 1'b1;
`else
      exp_cpu = ((i / 4) % 2) == 0;
`endif
      checks++; if (cpu_gnt !== exp_cpu || dma_gnt !== !exp_cpu) begin errors++; $display("FAIL rr_gnt%0d got %0b%0b expected %0b%0b", i, cpu_gnt, dma_gnt, exp_cpu, !exp_cpu); end
      checks++; if (cpu_gnt && dma_gnt) begin errors++; $display("FAIL rr_both%0d got 11 expected one-hot", i); end
      checks++; if (cpu_rvalid !== prev_cpu || dma_rvalid !== prev_dma) begin errors++; $display("FAIL rr_rvalid%0d got %0b%0b expected %0b%0b", i, cpu_rvalid, dma_rvalid, prev_cpu, prev_dma); end
      if (prev_cpu) begin
        checks++; if (cpu_rdata !== 32'hC0DE0040) begin errors++; $display("FAIL rr_cpu_rdata%0d got %0h expected c0de0040", i, cpu_rdata); end
      end
      if (prev_dma) begin
        checks++; if (dma_rdata !== 32'hC0DE0080) begin errors++; $display("FAIL rr_dma_rdata%0d got %0h expected c0de0080", i, dma_rdata); end
      end
      tick();
      prev_cpu = exp_cpu;
      prev_dma = !exp_cpu;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checks++; if (cpu_rvalid !== prev_cpu || dma_rvalid !== prev_dma) begin errors++; $display("FAIL rr_rvalid_last got %0b%0b expected %0b%0b", cpu_rvalid, dma_rvalid, prev_cpu, prev_dma); end
    tick();
  endtask

  task automatic test_cancel;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0030; dma_wdata = 32'h55555555;
    #1;
    checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL cancel_first got %0b%0b%0b expected 100", cpu_gnt, dma_gnt, mem_wen); end
    tick();
    dma_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dma_gnt !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("FAIL cancel_idle%0d got %0b/%0b expected 0/0", i, dma_gnt, mem_wen); end
      tick();
    end
    cpu_addr = 16'h0030;
    #1;
    tick();
    cpu_req = 1'b0;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hC0DE0030) begin errors++; $display("FAIL cancel_mem got %0b/%0h expected 1/c0de0030", cpu_rvalid, cpu_rdata); end
    tick();
  endtask

  task automatic test_reset_mid;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    #1;
    checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %0b expected 1", cpu_gnt); end
    tick();
    cpu_req = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid got %0b expected 0", cpu_rvalid); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %0h expected 0", cpu_rdata); end
    checks++; if (arb_owner !== 2'b00) begin errors++; $display("FAIL rstmid_owner got %0h expected 0", arb_owner); end
    rst = 1'b0;
    tick();
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_after got %0b expected 0", cpu_rvalid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dma_only();
    test_round_robin();
    test_cancel();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
